// File: rtl/bubble_ctrl_sequencer_if.sv
// ============================================================================
// Module   : bubble_ctrl_sequencer_if
// Brief    : Command handshake and bubble control bus between the sequencer
//            (master) and the host / emulator timing generator (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bubble_ctrl_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [11:0] cmd_page;
    logic        busy;
    logic        done;
    logic        n_bss;
    logic        n_bsen;
    logic        n_repen;
    logic        n_booten;
    logic        n_swapen;
    logic [11:0] position;

    modport master (
        input  cmd_valid, cmd_type, cmd_page,
        output cmd_ready, busy, done, n_bss, n_bsen, n_repen, n_booten, n_swapen, position
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_page,
        input  cmd_ready, busy, done, n_bss, n_bsen, n_repen, n_booten, n_swapen, position
    );
endinterface

`default_nettype wire

// File: rtl/bubble_ctrl_sequencer.sv
// ============================================================================
// Module   : bubble_ctrl_sequencer
// Brief    : Turns BOOT/READ/WRITE commands into cycle-accurate bubble control
//            waveforms and tracks the absolute minor-loop position.
//            Option macro BUBBLE_SEQ_REPTRAIN_EN: nREPEN pulse every READ LOAD cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bubble_ctrl_sequencer #(
    parameter int CYCLE_CLKS  = 480,
    parameter int LOOP_LEN    = 2053,
    parameter int INIT_POS    = 0,
    parameter int BSS_CLKS    = 48,
    parameter int PULSE_CLKS  = 24,
    parameter int BOOT_CYCLES = 4106,
    parameter int PAGE_CYCLES = 682
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    bubble_ctrl_sequencer_if.master  bus
);

    localparam logic [8:0]  c_PHASE_LAST = 9'(CYCLE_CLKS - 1);
    localparam logic [8:0]  c_PULSE_LAST = 9'(PULSE_CLKS - 1);
    localparam logic [11:0] c_POS_LAST   = 12'(LOOP_LEN - 1);
    localparam logic [11:0] c_POS_INIT   = 12'(INIT_POS);
    localparam logic [12:0] c_BSS_LAST   = 13'(BSS_CLKS - 1);
    localparam logic [12:0] c_GAP_LAST   = 13'(CYCLE_CLKS - 1);
    localparam logic [12:0] c_BOOT_LAST  = 13'(BOOT_CYCLES - 1);
    localparam logic [12:0] c_PAGE_LAST  = 13'(PAGE_CYCLES - 1);
    localparam logic [1:0]  c_T_BOOT     = 2'b00;
    localparam logic [1:0]  c_T_READ     = 2'b01;
    localparam logic [1:0]  c_T_WRITE    = 2'b10;
    localparam logic [1:0]  c_T_RSVD     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BSS  = 3'd1,
        S_GAP  = 3'd2,
        S_SPIN = 3'd3,
        S_LOAD = 3'd4,
        S_STOP = 3'd5
    } state_t;

    state_t      r_state,   w_state_nxt;
    logic [8:0]  r_phase,   w_phase_nxt;
    logic [8:0]  r_pcnt,    w_pcnt_nxt;
    logic [12:0] r_cnt,     w_cnt_nxt;
    logic [1:0]  r_type,    w_type_nxt;
    logic [11:0] r_page,    w_page_nxt;
    logic [11:0] r_pos,     w_pos_nxt;
    logic        r_ready,   w_ready_nxt;
    logic        r_busy,    w_busy_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_nbss,    w_nbss_nxt;
    logic        r_nbsen,   w_nbsen_nxt;
    logic        r_nrepen,  w_nrepen_nxt;
    logic        r_nbooten, w_nbooten_nxt;
    logic        r_nswapen, w_nswapen_nxt;

    logic        w_wrap;
    logic [11:0] w_pos_inc;
    logic        w_enter_load;

    assign w_wrap    = !r_nbsen && (r_phase == c_PHASE_LAST);
    assign w_pos_inc = (r_pos == c_POS_LAST) ? 12'd0 : r_pos + 12'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pcnt_nxt    = r_pcnt;
        w_type_nxt    = r_type;
        w_page_nxt    = r_page;
        w_ready_nxt   = r_ready;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_nbss_nxt    = r_nbss;
        w_nbsen_nxt   = r_nbsen;
        w_nrepen_nxt  = r_nrepen;
        w_nbooten_nxt = r_nbooten;
        w_nswapen_nxt = r_nswapen;
        w_enter_load  = 1'b0;
        w_phase_nxt   = (r_nbsen || w_wrap) ? 9'd0 : r_phase + 9'd1;
        w_pos_nxt     = w_wrap ? w_pos_inc : r_pos;

        // Pulses are shorter than a bubble cycle, so a release never collides with a start.
        if (!r_nrepen || !r_nswapen) begin
            if (r_pcnt == c_PULSE_LAST) begin
                w_nrepen_nxt  = 1'b1;
                w_nswapen_nxt = 1'b1;
                w_pcnt_nxt    = 9'd0;
            end else begin
                w_pcnt_nxt = r_pcnt + 9'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && r_ready) begin
                    w_type_nxt  = bus.cmd_type;
                    w_page_nxt  = bus.cmd_page;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = 13'd0;
                    if (bus.cmd_type == c_T_RSVD || bus.cmd_page > c_POS_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_nbss_nxt  = 1'b0;
                        w_state_nxt = S_BSS;
                        if (bus.cmd_type == c_T_BOOT) begin
                            w_nbooten_nxt = 1'b0;
                        end
                    end
                end
            end
            S_BSS: begin
                if (r_cnt == c_BSS_LAST) begin
                    w_nbss_nxt  = 1'b1;
                    w_cnt_nxt   = 13'd0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 13'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_nbsen_nxt = 1'b0;
                    // A zero-length seek starts LOAD on the very first rotating cycle.
                    if (r_type == c_T_BOOT || r_pos == r_page) begin
                        w_enter_load = 1'b1;
                    end else begin
                        w_state_nxt = S_SPIN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 13'd1;
                end
            end
            S_SPIN: begin
                if (w_wrap && w_pos_inc == r_page) begin
                    w_enter_load = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_wrap) begin
                    if (r_cnt == 13'd0) begin
                        w_state_nxt   = S_STOP;
                        w_done_nxt    = 1'b1;
                        w_nbsen_nxt   = 1'b1;
                        w_nbooten_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 13'd1;
`ifdef BUBBLE_SEQ_REPTRAIN_EN
                        if (r_type == c_T_READ) begin
                            w_nrepen_nxt = 1'b0;
                            w_pcnt_nxt   = 9'd0;
                        end
`endif
                    end
                end
            end
            S_STOP: begin
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_enter_load) begin
            w_state_nxt = S_LOAD;
            w_pcnt_nxt  = 9'd0;
            case (r_type)
                c_T_READ: begin
                    w_cnt_nxt    = c_PAGE_LAST;
                    w_nrepen_nxt = 1'b0;
                end
                c_T_WRITE: begin
                    w_cnt_nxt     = 13'd0;
                    w_nswapen_nxt = 1'b0;
                end
                default: begin
                    w_cnt_nxt = c_BOOT_LAST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= 9'd0;
            r_pcnt    <= 9'd0;
            r_cnt     <= 13'd0;
            r_type    <= 2'b00;
            r_page    <= 12'd0;
            r_pos     <= c_POS_INIT;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_nbss    <= 1'b1;
            r_nbsen   <= 1'b1;
            r_nrepen  <= 1'b1;
            r_nbooten <= 1'b1;
            r_nswapen <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_type    <= w_type_nxt;
            r_page    <= w_page_nxt;
            r_pos     <= w_pos_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_nbss    <= w_nbss_nxt;
            r_nbsen   <= w_nbsen_nxt;
            r_nrepen  <= w_nrepen_nxt;
            r_nbooten <= w_nbooten_nxt;
            r_nswapen <= w_nswapen_nxt;
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.n_bss     = r_nbss;
    assign bus.n_bsen    = r_nbsen;
    assign bus.n_repen   = r_nrepen;
    assign bus.n_booten  = r_nbooten;
    assign bus.n_swapen  = r_nswapen;
    assign bus.position  = r_pos;

endmodule

`default_nettype wire

// File: tb/tb_bubble_ctrl_sequencer.sv
// ============================================================================
// Module   : tb_bubble_ctrl_sequencer
// Brief    : Self-checking bench for bubble_ctrl_sequencer with a waveform
//            reference model evaluated every clock after command acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bubble_ctrl_sequencer;

    localparam int CYC   = 10;
    localparam int L     = 23;
    localparam int INIT  = 4;
    localparam int BSS   = 4;
    localparam int PULSE = 3;
    localparam int BOOTC = 46;
    localparam int PAGEC = 7;
`ifdef BUBBLE_SEQ_REPTRAIN_EN
    localparam int REP_N = PAGEC;
`else
    localparam int REP_N = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    bubble_ctrl_sequencer_if bus();

    bubble_ctrl_sequencer #(
        .CYCLE_CLKS (CYC),
        .LOOP_LEN   (L),
        .INIT_POS   (INIT),
        .BSS_CLKS   (BSS),
        .PULSE_CLKS (PULSE),
        .BOOT_CYCLES(BOOTC),
        .PAGE_CYCLES(PAGEC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state for the command in flight
    int  m_pos;
    int  c_type, c_page, c_start, c_seek, c_load;
    bit  c_ok;

    function automatic logic [19:0] pack(input logic bss, bsen, rep, boot, swp, dn, rdy, bsy,
                                         input int pos);
        logic [11:0] p;
        p = 12'(pos);
        return {bss, bsen, rep, boot, swp, dn, rdy, bsy, p};
    endfunction

    function automatic logic [19:0] idle_vec(input int pos);
        return pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pos);
    endfunction

    // Expected bus state t clocks after the accepting edge
    function automatic logic [19:0] exp_at(input int t);
        int t0, n, td, m, s;
        logic bss, bsen, rep, boot, swp;
        bss = 1'b1; bsen = 1'b1; rep = 1'b1; boot = 1'b1; swp = 1'b1;
        if (!c_ok) begin
            return pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, (t == 1), (t >= 2), (t == 1), c_start);
        end
        t0 = BSS + CYC + 1;
        n  = c_seek + c_load;
        td = t0 + n * CYC;
        if (t >= 1 && t <= BSS) bss = 1'b0;
        if (t >= t0 && t < td) bsen = 1'b0;
        if (c_type == 0 && t >= 1 && t < td) boot = 1'b0;
        if (c_type == 1) begin
            for (int k = 0; k < REP_N; k++) begin
                s = t0 + (c_seek + k) * CYC;
                if (t >= s && t < s + PULSE) rep = 1'b0;
            end
        end
        if (c_type == 2) begin
            s = t0 + c_seek * CYC;
            if (t >= s && t < s + PULSE) swp = 1'b0;
        end
        m = (t < t0) ? 0 : (t - t0) / CYC;
        if (m > n) m = n;
        return pack(bss, bsen, rep, boot, swp, (t == td), (t > td), (t >= 1 && t <= td),
                    (c_start + m) % L);
    endfunction

    task automatic check(input string tag, input int t, input logic [19:0] e);
        logic [19:0] o;
        o = {bus.n_bss, bus.n_bsen, bus.n_repen, bus.n_booten, bus.n_swapen,
             bus.done, bus.cmd_ready, bus.busy, bus.position};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
        end
    endtask

    // Issue one command, check every clock until idle; optionally reset at clock reset_at
    task automatic run_cmd(input string tag, input int typ, input int page, input int reset_at);
        int w, tend;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_idle"}, 0, idle_vec(m_pos));

        c_type  = typ;
        c_page  = page;
        c_start = m_pos;
        c_ok    = (typ != 3) && (page < L);
        c_seek  = (typ == 0) ? 0 : (page - m_pos + L) % L;
        c_load  = (typ == 0) ? BOOTC : (typ == 1) ? PAGEC : 1;
        tend    = c_ok ? (BSS + CYC + 1 + (c_seek + c_load) * CYC + 2) : 3;

        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'(typ);
        bus.cmd_page  = 12'(page);
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            if (reset_at > 0 && t == reset_at) begin
                bus.cmd_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 check({tag, "_async_rst"}, t, idle_vec(INIT));
                @(posedge clk);
                #1 check({tag, "_rst_held"}, t, idle_vec(INIT));
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check({tag, "_after_rst"}, t, idle_vec(INIT));
                m_pos = INIT;
                return;
            end
            check(tag, t, exp_at(t));
            bus.cmd_valid = (t < tend - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cmd_type  = 2'($urandom_range(0, 3));
            bus.cmd_page  = 12'($urandom_range(0, 4095));
        end
        bus.cmd_valid = 1'b0;
        if (c_ok) m_pos = (c_start + c_seek + c_load) % L;
        check({tag, "_end"}, tend, idle_vec(m_pos));
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'b00;
        bus.cmd_page  = 12'd0;
        m_pos = INIT;

        #1 rst_n = 1'b0;
        #1 check("reset", 0, idle_vec(INIT));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", 0, idle_vec(INIT));

        run_cmd("boot",        0, 9, 0);
        run_cmd("read_zero",   1, m_pos, 0);
        run_cmd("write_wrap",  2, (m_pos + L - 1) % L, 0);
        run_cmd("read_last",   1, L - 1, 0);
        run_cmd("bad_page_L",  1, L, 0);
        run_cmd("bad_page_max",2, 4095, 0);
        run_cmd("reserved",    3, 0, 0);
        run_cmd("reset_spin",  1, (m_pos + 5) % L, BSS + CYC + 1 + CYC + 4);
        run_cmd("read_init",   1, (m_pos + 2) % L, 0);

        for (int i = 0; i < 12; i++) begin
            int typ, page;
            typ  = $urandom_range(0, 3);
            page = ($urandom_range(0, 7) == 0) ? $urandom_range(L, 4095) : $urandom_range(0, L - 1);
            run_cmd("random", typ, page, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
